// File: rtl/commutator_decim_ring_counter.sv
// One-hot ring counter that steps one position per enabled clock.
// Shared by the decimation input commutator and the interpolation output commutator.
module ring_counter #(
    parameter int unsigned width     = 4,
    parameter bit          direction = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    output logic [width-1:0] o_onehot,
    output logic             o_wrap
);

    localparam logic [width-1:0] FIRST = direction ? width'(1) : (width'(1) << (width - 1));

    // direction=1 walks bit 0 up to width-1; direction=0 walks width-1 down to 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_onehot <= FIRST;
        end else if (i_ena) begin
            if (direction) begin
                o_onehot <= {o_onehot[width-2:0], o_onehot[width-1]};
            end else begin
                o_onehot <= {o_onehot[0], o_onehot[width-1:1]};
            end
        end
    end

    // High while the counter sits on the final position of its sweep
    assign o_wrap = direction ? o_onehot[width-1] : o_onehot[0];

endmodule

// File: rtl/commutator_decim.sv
// Serial-to-parallel input commutator for polyphase decimators: spreads consecutive
// samples over M branches and presents the completed set as one frame with a strobe.
module commutator_decim #(
    parameter bit          gp_ccw               = 1'b1,
    parameter int unsigned gp_idata_width       = 26,
    parameter int unsigned gp_decimation_factor = 32,
    parameter int unsigned gp_phase             = 0
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_ena,
    input  logic signed [gp_idata_width-1:0]                 i_data,
    output logic [gp_decimation_factor*gp_idata_width-1:0]   o_data,
    output logic                                             o_valid,
    output logic [$clog2(gp_decimation_factor):0]            o_idx
);

    localparam int unsigned W         = gp_idata_width;
    localparam int unsigned M         = gp_decimation_factor;
    localparam int unsigned IDX_W     = $clog2(M) + 1;
    localparam int unsigned LAST_BR   = gp_ccw ? M - 1 : 0;
    localparam logic [IDX_W-1:0] FIRST_IDX = gp_ccw ? IDX_W'(0) : IDX_W'(M - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = gp_ccw ? IDX_W'(M - 1) : IDX_W'(0);

    logic             skip_active;
    logic             accept;
    logic             frame_done;
    logic [M-1:0]     onehot;
    logic             wrap;
    logic [W-1:0]     cap [M];
    logic [M*W-1:0]   frame_next;
    logic [IDX_W-1:0] idx_next;

    // Post-reset phase alignment: drop the first gp_phase enabled samples
    generate
        if (gp_phase > 0) begin : g_skip
            localparam int unsigned SKIP_W = $clog2(gp_phase + 1);
            logic [SKIP_W-1:0] skip_cnt;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    skip_cnt <= SKIP_W'(gp_phase);
                end else if (i_ena && (skip_cnt != '0)) begin
                    skip_cnt <= skip_cnt - SKIP_W'(1);
                end
            end

            assign skip_active = (skip_cnt != '0);
        end else begin : g_no_skip
            assign skip_active = 1'b0;
        end
    endgenerate

    assign accept     = i_ena & ~skip_active;
    assign frame_done = accept & wrap;

    ring_counter #(
        .width     (M),
        .direction (gp_ccw)
    ) u_ring (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ena    (accept),
        .o_onehot (onehot),
        .o_wrap   (wrap)
    );

    // Per-branch capture, enabled by the one-hot position
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < M; b++) begin
                cap[b] <= '0;
            end
        end else if (accept) begin
            for (int b = 0; b < M; b++) begin
                if (onehot[b]) begin
                    cap[b] <= i_data;
                end
            end
        end
    end

    // Completed frame: earlier captures plus the sample arriving on this edge
    always_comb begin
        frame_next = '0;
        for (int b = 0; b < M; b++) begin
            frame_next[b*W +: W] = cap[b];
        end
        frame_next[LAST_BR*W +: W] = i_data;
    end

    always_comb begin
        idx_next = o_idx;
        if (o_idx == LAST_IDX) begin
            idx_next = FIRST_IDX;
        end else if (gp_ccw) begin
            idx_next = o_idx + IDX_W'(1);
        end else begin
            idx_next = o_idx - IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_idx   <= FIRST_IDX;
        end else begin
            o_valid <= frame_done;
            if (frame_done) begin
                o_data <= frame_next;
            end
            if (accept) begin
                o_idx <= idx_next;
            end
        end
    end

endmodule

// File: tb/tb_commutator_decim.sv
// Drives five commutator configurations from one shared random/directed stream and
// compares every output against a frame-counting reference model each cycle.
module tb_commutator_decim;

    localparam int NDUT = 5;
    localparam int CFG_M   [NDUT] = '{4, 4, 4, 32, 5};
    localparam int CFG_W   [NDUT] = '{8, 8, 8, 26, 8};
    localparam int CFG_PH  [NDUT] = '{0, 0, 2, 0, 3};
    localparam int CFG_CCW [NDUT] = '{1, 0, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic [25:0] din = '0;

    logic [31:0]  d0, d1, d2;
    logic [831:0] d3;
    logic [39:0]  d4;
    logic [2:0]   idx0, idx1, idx2;
    logic [5:0]   idx3;
    logic [3:0]   idx4;
    logic         v0, v1, v2, v3, v4;

    logic [1023:0] got_data  [NDUT];
    logic [7:0]    got_idx   [NDUT];
    logic          got_valid [NDUT];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: accepted-sample count since reset, branch contents, last frame
    int            n_seen  [NDUT];
    logic [25:0]   br_val  [NDUT][32];
    logic [1023:0] m_frame [NDUT];
    logic          m_valid [NDUT];

    always #5 clk = ~clk;

    commutator_decim #(.gp_ccw(1'b1), .gp_idata_width(8), .gp_decimation_factor(4), .gp_phase(0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din[7:0]), .o_data(d0), .o_valid(v0), .o_idx(idx0));
    commutator_decim #(.gp_ccw(1'b0), .gp_idata_width(8), .gp_decimation_factor(4), .gp_phase(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din[7:0]), .o_data(d1), .o_valid(v1), .o_idx(idx1));
    commutator_decim #(.gp_ccw(1'b1), .gp_idata_width(8), .gp_decimation_factor(4), .gp_phase(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din[7:0]), .o_data(d2), .o_valid(v2), .o_idx(idx2));
    commutator_decim #(.gp_ccw(1'b1), .gp_idata_width(26), .gp_decimation_factor(32), .gp_phase(0)) u3 (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din), .o_data(d3), .o_valid(v3), .o_idx(idx3));
    commutator_decim #(.gp_ccw(1'b0), .gp_idata_width(8), .gp_decimation_factor(5), .gp_phase(3)) u4 (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(din[7:0]), .o_data(d4), .o_valid(v4), .o_idx(idx4));

    assign got_data[0] = 1024'(d0);
    assign got_data[1] = 1024'(d1);
    assign got_data[2] = 1024'(d2);
    assign got_data[3] = 1024'(d3);
    assign got_data[4] = 1024'(d4);
    assign got_idx[0]  = 8'(idx0);
    assign got_idx[1]  = 8'(idx1);
    assign got_idx[2]  = 8'(idx2);
    assign got_idx[3]  = 8'(idx3);
    assign got_idx[4]  = 8'(idx4);
    assign got_valid[0] = v0;
    assign got_valid[1] = v1;
    assign got_valid[2] = v2;
    assign got_valid[3] = v3;
    assign got_valid[4] = v4;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Sample k after the skipped ones lands in position k mod M of the sweep
    task automatic model_step();
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                n_seen[d]  = 0;
                m_valid[d] = 1'b0;
                m_frame[d] = '0;
                for (int b = 0; b < 32; b++) br_val[d][b] = '0;
            end else begin
                m_valid[d] = 1'b0;
                if (ena) begin
                    if (n_seen[d] < CFG_PH[d]) begin
                        n_seen[d]++;
                    end else begin
                        int p;
                        int br;
                        logic [25:0] msk;
                        p   = (n_seen[d] - CFG_PH[d]) % CFG_M[d];
                        br  = (CFG_CCW[d] != 0) ? p : CFG_M[d] - 1 - p;
                        msk = ~({26{1'b1}} << CFG_W[d]);
                        br_val[d][br] = din & msk;
                        n_seen[d]++;
                        if (p == CFG_M[d] - 1) begin
                            m_valid[d] = 1'b1;
                            m_frame[d] = '0;
                            for (int b = 0; b < CFG_M[d]; b++)
                                for (int k = 0; k < CFG_W[d]; k++)
                                    m_frame[d][b*CFG_W[d] + k] = br_val[d][b][k];
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < NDUT; d++) begin
            int p;
            int e_idx;
            p     = (n_seen[d] < CFG_PH[d]) ? 0 : (n_seen[d] - CFG_PH[d]) % CFG_M[d];
            e_idx = (CFG_CCW[d] != 0) ? p : CFG_M[d] - 1 - p;
            check($sformatf("dut%0d.valid", d), 1024'(got_valid[d]), 1024'(m_valid[d]));
            check($sformatf("dut%0d.idx", d), 1024'(got_idx[d]), 1024'(e_idx));
            check($sformatf("dut%0d.data", d), got_data[d], m_frame[d]);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [25:0] x);
        rst = r;
        ena = e;
        din = x;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] samples [4];
        logic       pattern [7];
        int         si;
        int         pulses;

        samples = '{8'h80, 8'h7F, 8'h01, 8'hFF};
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        cycle(1'b1, 1'b0, 26'd0);
        cycle(1'b1, 1'b1, 26'd55);

        // Ramp 1..8: basic ccw/cw frames and phase-2 skip
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 26'(i));
            if (i == 4) begin
                check("ccw_first_frame", 1024'(d0), 1024'(32'h04030201));
                check("cw_first_frame", 1024'(d1), 1024'(32'h01020304));
            end
            if (i == 6) check("phase2_frame", 1024'(d2), 1024'(32'h06050403));
            if (i == 8) check("cw_second_frame", 1024'(d1), 1024'(32'h05060708));
        end
        cycle(1'b0, 1'b0, 26'd0);

        // Enable gaps with extreme byte values
        cycle(1'b1, 1'b0, 26'd0);
        si = 0;
        for (int i = 0; i < 7; i++) begin
            if (pattern[i]) begin
                cycle(1'b0, 1'b1, 26'(samples[si]));
                si++;
            end else begin
                cycle(1'b0, 1'b0, 26'($urandom));
            end
        end
        check("gap_frame", 1024'(d0), 1024'(32'hFF017F80));
        cycle(1'b0, 1'b0, 26'($urandom));

        // Reset in the middle of a frame
        cycle(1'b1, 1'b0, 26'd0);
        cycle(1'b0, 1'b1, 26'd1);
        cycle(1'b0, 1'b1, 26'd2);
        cycle(1'b1, 1'b1, 26'd3);
        for (int i = 9; i <= 12; i++) cycle(1'b0, 1'b1, 26'(i));
        check("post_reset_frame", 1024'(d0), 1024'(32'h0C0B0A09));

        // Continuous ramp for the 32-branch configuration
        cycle(1'b1, 1'b0, 26'd0);
        pulses = 0;
        for (int i = 0; i < 96; i++) begin
            cycle(1'b0, 1'b1, 26'(i));
            if (v3) pulses++;
        end
        check("m32_pulse_count", 1024'(pulses), 1024'(3));
        cycle(1'b0, 1'b0, 26'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), 26'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
